// File: rtl/ifetch_buffer_if.sv
// Fetch-stage bus bundle: PC handshake, instruction-memory req/ack port and
// the valid/ready instruction stream into decode.
interface ifetch_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] pcAddr;
  logic          flush;
  logic          pcStall;
  logic          imemReq;
  logic [AW-1:0] imemAddr;
  logic          imemAck;
  logic [DW-1:0] imemData;
  logic          instValid;
  logic          instReady;
  logic [DW-1:0] instr;
  logic [AW-1:0] instAddr;

  // Fetch stage side
  modport master (
    input  pcAddr, flush, imemAck, imemData, instReady,
    output pcStall, imemReq, imemAddr, instValid, instr, instAddr
  );

  // Environment side (PC stage, instruction memory, decode)
  modport slave (
    output pcAddr, flush, imemAck, imemData, instReady,
    input  pcStall, imemReq, imemAddr, instValid, instr, instAddr
  );
endinterface

// File: rtl/ifetch_buffer.sv
// Instruction fetch buffer: captures the PC address, runs one req/ack read at
// a time against instruction memory and queues returned words with their
// addresses for decode. A flush empties the queue and discards the word of
// any fetch still in flight.
//
// state | meaning
// IDLE  | no fetch outstanding; may capture a new PC address
// REQ   | imemReq high, waiting for the ack whose word will be queued
// DROP  | flushed while waiting; the returning word is thrown away
module ifetch_buffer #(
  parameter int DEPTH = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic           CLK,
  input  logic           RST_N,
  ifetch_buffer_if.master bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state, state_nxt;
  logic          req;
  logic [AW-1:0] req_addr;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [DW-1:0] data_q [DEPTH];
  logic [AW-1:0] addr_q [DEPTH];
  logic          valid, not_full, issue, push, pop;

  assign valid    = (count != '0);
  assign not_full = (count < CW'(DEPTH));
  assign issue    = (state == IDLE) && not_full && !bus.flush;
  // A flush cancels both the queueing of a returning word and a pop.
  assign push     = (state == REQ) && bus.imemAck && !bus.flush;
  assign pop      = valid && bus.instReady && !bus.flush;

  // Next-state selection; ack is only meaningful while a request is out.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (issue) state_nxt = REQ;
      REQ: begin
        if (bus.imemAck)    state_nxt = IDLE;
        else if (bus.flush) state_nxt = DROP;
      end
      DROP: if (bus.imemAck) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Memory request register; the request is held until acked, even across a flush.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      req      <= 1'b0;
      req_addr <= '0;
    end else if (issue) begin
      req      <= 1'b1;
      req_addr <= bus.pcAddr;
    end else if (state != IDLE && bus.imemAck) begin
      req      <= 1'b0;
    end
  end

  // Queue pointers and occupancy; flush takes priority over push/pop.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage; contents are only visible through the valid-gated outputs.
  always_ff @(posedge CLK) begin
    if (push) begin
      data_q[wr_ptr] <= bus.imemData;
      addr_q[wr_ptr] <= req_addr;
    end
  end

  assign bus.imemReq   = req;
  assign bus.imemAddr  = req_addr;
  assign bus.instValid = valid;
  assign bus.instr     = valid ? data_q[rd_ptr] : '0;
  assign bus.instAddr  = valid ? addr_q[rd_ptr] : '0;
  // PC holds unless its address is captured now or it is taking a redirect.
  assign bus.pcStall   = !RST_N || (!issue && !bus.flush);

endmodule

// File: tb/tb_ifetch_buffer.sv
// Bench for ifetch_buffer: directed scenarios followed by a randomized run,
// all checked cycle by cycle against a queue-based behavioural model.
module tb_ifetch_buffer;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  ifetch_buffer_if #(.AW(32), .DW(32)) bus ();

  ifetch_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model: one optional outstanding fetch plus a queue of {addr, data}.
  bit          m_pend, m_drop;
  logic [31:0] m_paddr;
  logic [63:0] mq[$];
  logic [31:0] pc_reg;
  logic [31:0] seen[$];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] seen_at(input int i);
    return (i < seen.size()) ? seen[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pend  = 0;
    m_drop  = 0;
    m_paddr = '0;
    mq.delete();
    seen.delete();
  endtask

  task automatic check_outputs();
    chk("imemReq",   bus.imemReq, m_pend);
    chk("imemAddr",  bus.imemAddr, m_paddr);
    chk("instValid", bus.instValid, mq.size() != 0);
    chk("instr",     bus.instr, (mq.size() != 0) ? mq[0][31:0] : 32'h0);
    chk("instAddr",  bus.instAddr, (mq.size() != 0) ? mq[0][63:32] : 32'h0);
  endtask

  // ackmode: 0 never, 1 whenever requested, 2 random, 3 forced high
  task automatic cyc(input bit fl, input bit rdy, input int ackmode, input logic [31:0] redir);
    bit ack, issue, pop, exp_stall;
    case (ackmode)
      0:       ack = 1'b0;
      1:       ack = bus.imemReq;
      2:       ack = ($urandom_range(0, 2) == 0);
      default: ack = 1'b1;
    endcase
    bus.pcAddr    = pc_reg;
    bus.flush     = fl;
    bus.instReady = rdy;
    bus.imemAck   = ack;
    bus.imemData  = mem_fn(bus.imemAddr);
    #1;
    issue     = !m_pend && (mq.size() < DEPTH) && !fl;
    exp_stall = !issue && !fl;
    chk("pcStall", bus.pcStall, exp_stall);
    if (bus.instValid && rdy && !fl) seen.push_back(bus.instAddr);
    @(posedge clk);
    pop = (mq.size() != 0) && rdy && !fl;
    if (fl) mq.delete();
    else if (pop) void'(mq.pop_front());
    if (m_pend && ack) begin
      if (!m_drop && !fl) mq.push_back({m_paddr, mem_fn(m_paddr)});
      m_pend = 0;
      m_drop = 0;
    end else if (m_pend && fl) begin
      m_drop = 1;
    end
    if (issue) begin
      m_pend  = 1;
      m_drop  = 0;
      m_paddr = pc_reg;
    end
    if (fl) pc_reg = redir;
    else if (!exp_stall) pc_reg = pc_reg + 32'd4;
    #1;
    check_outputs();
  endtask

  // Hold reset for two edges, then release just after a posedge.
  task automatic do_reset(input logic [31:0] start);
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.imemAck   = 1'b0;
    bus.instReady = 1'b0;
    bus.imemData  = '0;
    bus.pcAddr    = start;
    model_reset();
    #1;
    chk("rst_pcStall", bus.pcStall, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("rst_pcStall2", bus.pcStall, 1'b1);
    rst_n  = 1'b1;
    pc_reg = start;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Zero-wait stream with decode always ready.
    do_reset(32'd1040);
    repeat (7) cyc(0, 1, 1, 0);
    chk("t1_n", seen.size(), 3);
    chk("t1_a0", seen_at(0), 32'd1040);
    chk("t1_a1", seen_at(1), 32'd1044);
    chk("t1_a2", seen_at(2), 32'd1048);

    // Decode blocked: queue fills, fetching stops, then drains in order.
    do_reset(32'd1040);
    repeat (8) cyc(0, 0, 1, 0);
    chk("t2_stall", bus.pcStall, 1'b1);
    chk("t2_req", bus.imemReq, 1'b0);
    chk("t2_head", bus.instAddr, 32'd1040);
    repeat (8) cyc(0, 1, 1, 0);
    chk("t2_a0", seen_at(0), 32'd1040);
    chk("t2_a1", seen_at(1), 32'd1044);
    chk("t2_a2", seen_at(2), 32'd1048);

    // Three wait cycles: request and address held for four cycles.
    do_reset(32'd1040);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t3_req", bus.imemReq, 1'b1);
      chk("t3_addr", bus.imemAddr, 32'd1040);
      chk("t3_stall", bus.pcStall, 1'b1);
      cyc(0, 1, (i == 3) ? 3 : 0, 0);
    end
    chk("t3_valid", bus.instValid, 1'b1);
    chk("t3_instr", bus.instr, mem_fn(32'd1040));

    // Flush during REQ, late ack discarded, redirect fetched.
    do_reset(32'd1040);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 32'd2000);
    cyc(0, 0, 0, 0);
    chk("t4_req_held", bus.imemReq, 1'b1);
    cyc(0, 0, 3, 0);
    chk("t4_valid", bus.instValid, 1'b0);
    repeat (4) cyc(0, 1, 1, 0);
    chk("t4_a0", seen_at(0), 32'd2000);

    // Flush with ack, then flush with pop of a full queue.
    do_reset(32'd1040);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 3, 32'd3000);
    chk("t5_valid_a", bus.instValid, 1'b0);
    chk("t5_req_a", bus.imemReq, 1'b0);
    repeat (6) cyc(0, 0, 1, 0);
    chk("t5_full", bus.pcStall, 1'b1);
    cyc(1, 1, 0, 32'd4000);
    chk("t5_valid_b", bus.instValid, 1'b0);
    chk("t5_nopop", seen.size(), 0);
    repeat (4) cyc(0, 1, 1, 0);
    chk("t5_a0", seen_at(0), 32'd4000);

    // Asynchronous reset mid-REQ with one queued entry.
    do_reset(32'd1040);
    repeat (3) cyc(0, 0, 1, 0);
    chk("t6_pre_req", bus.imemReq, 1'b1);
    chk("t6_pre_valid", bus.instValid, 1'b1);
    bus.imemAck = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_req", bus.imemReq, 1'b0);
    chk("t6_addr", bus.imemAddr, 32'h0);
    chk("t6_valid", bus.instValid, 1'b0);
    chk("t6_instr", bus.instr, 32'h0);
    chk("t6_iaddr", bus.instAddr, 32'h0);
    chk("t6_stall", bus.pcStall, 1'b1);
    @(posedge clk);
    #1;
    do_reset(32'd5000);
    repeat (6) cyc(0, 1, 1, 0);
    chk("t6_a0", seen_at(0), 32'd5000);

    // Randomized traffic: random ready, ack timing, flushes and redirects.
    do_reset(32'h100);
    repeat (1500)
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, 2,
          $urandom & 32'hFFFF_FFFC);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
